// File: rtl/adder_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter_if
// Bus bundle between the requesting datapath stages, the arbiter and the
// shared combinational approximate adder core.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   core_a/core_b       : operands driven to the shared core
//   core_sum            : combinational result returned by the core
//   resp_*              : single-entry output buffer with valid/ready
// The slave modport is the arbiter view; master is the surrounding view.
// ---------------------------------------------------------------------------
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 6
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [W-1:0]         core_a;
    logic [W-1:0]         core_b;
    logic [W-1:0]         core_sum;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [W-1:0]         resp_sum;
    logic                 resp_mismatch;

    modport slave (
        input  req_valid, req_a, req_b, core_sum, resp_ready,
        output req_ready, core_a, core_b, resp_valid, resp_id, resp_sum,
               resp_mismatch
    );

    modport master (
        output req_valid, req_a, req_b, core_sum, resp_ready,
        input  req_ready, core_a, core_b, resp_valid, resp_id, resp_sum,
               resp_mismatch
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
// Shares one external combinational approximate W-bit adder core among
// NUM_REQ requesters with round-robin arbitration. The granted operands are
// driven to the core in the handshake cycle and the result is captured into
// a single-entry output buffer. An exact sum is computed alongside, so the
// buffer can hold either the exact or the approximate result, and every
// result whose core_sum differs from the exact sum bumps a saturating
// mismatch counter.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : adder_share_arbiter_if.slave (requests, core, response)
//   mode_exact : 1 = return exact sum, 0 = return core_sum (sampled at handshake)
//   err_clr    : synchronous clear of err_cnt, wins over an increment
//   err_cnt    : saturating count of mismatching results
// ---------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 6,
    parameter int ERR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus,
    input  logic                  mode_exact,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err_cnt
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_d;
    logic [ID_W-1:0]      resp_id_q;
    logic [W-1:0]         resp_sum_q;
    logic                 resp_mismatch_q;
    logic [ERR_W-1:0]     err_cnt_q;
    logic [ERR_W-1:0]     err_cnt_d;

    logic [ID_W-1:0]      grant_idx;
    logic                 grant_found;
    logic                 slot_free;
    logic                 hs;
    logic [NUM_REQ-1:0]   req_ready_d;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic [W-1:0]         exact_sum;
    logic                 mismatch;
    logic [W-1:0]         sum_sel;

    // Round-robin search: first valid requester at or above the pointer,
    // wrapping modulo NUM_REQ (works for non-power-of-two NUM_REQ too).
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr_q) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!grant_found && bus.req_valid[idx_w]) begin
                grant_found = 1'b1;
                grant_idx   = idx_w;
            end
        end
    end

    // The slot can accept when empty, or when full and draining this cycle.
    // rst_n gates the handshake so req_ready stays low while reset is held.
    assign slot_free = (state_q == EMPTY) || bus.resp_ready;
    assign hs        = rst_n && slot_free && grant_found;

    always_comb begin
        req_ready_d = '0;
        op_a        = '0;
        op_b        = '0;
        if (hs) begin
            req_ready_d[grant_idx] = 1'b1;
            op_a = bus.req_a[grant_idx*W +: W];
            op_b = bus.req_b[grant_idx*W +: W];
        end
    end

    // W-bit modulo addition; the carry-out is intentionally dropped.
    assign exact_sum = op_a + op_b;
    assign mismatch  = (bus.core_sum != exact_sum);
    assign sum_sel   = mode_exact ? exact_sum : bus.core_sum;

    assign ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (hs && mismatch && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Buffer FSM plus capture registers. A handshake while FULL is a
    // drain-and-refill, so FULL stays FULL and the new result replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EMPTY;
            ptr_q           <= '0;
            resp_id_q       <= '0;
            resp_sum_q      <= '0;
            resp_mismatch_q <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (hs) begin
                resp_id_q       <= grant_idx;
                resp_sum_q      <= sum_sel;
                resp_mismatch_q <= mismatch;
                ptr_q           <= ptr_d;
            end
            case (state_q)
                EMPTY: begin
                    if (hs) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (!hs && bus.resp_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_d;
    assign bus.core_a        = op_a;
    assign bus.core_b        = op_b;
    assign bus.resp_valid    = (state_q == FULL);
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_sum      = resp_sum_q;
    assign bus.resp_mismatch = resp_mismatch_q;
    assign err_cnt           = err_cnt_q;
endmodule
